// File: rtl/user_io_pkg.sv
// Shared constants for the user I/O slice: pin map, output-enable encoding,
// conditioned channel order and debounce depth defaults.
package user_io_pkg;

    localparam int PIN_RESET  = 23;
    localparam int PIN_ENABLE = 22;
    localparam int PIN_SWITCH = 11;
    localparam int PIN_BUTTON = 10;

    // Bit positions inside the conditioner's channel vectors
    localparam int CH_RESET  = 0;
    localparam int CH_ENABLE = 1;
    localparam int CH_SWITCH = 2;
    localparam int CH_BUTTON = 3;

    localparam logic OUTPUT_ENABLE  = 1'b1;
    localparam logic OUTPUT_DISABLE = 1'b0;

    localparam int DEBOUNCE_CYCLES_HW  = 50000;
    localparam int DEBOUNCE_CYCLES_SIM = 4;

    // A single-cycle debounce still needs one counter bit
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One conditioned pin: synchroniser chain, stability counter, debounced level,
// registered rise/fall pulses and a press-toggled level.
module debounce_channel
    import user_io_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_HW
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic toggle
);
    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   synced;
    logic                   mismatch;
    logic                   accept;

    assign synced   = sync_q[SYNC_STAGES-1];
    assign mismatch = synced ^ level;
    // Counter saturates at CNT_LAST and clears on acceptance, so it never wraps
    assign accept   = mismatch && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt    <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
            toggle <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            if (!mismatch || accept) cnt <= '0;
            else                     cnt <= cnt + 1'b1;
            if (accept) level <= synced;
            rise   <= accept & synced;
            fall   <= accept & ~synced;
            toggle <= toggle ^ (accept & synced);
        end
    end

endmodule

// File: rtl/io_input_conditioner.sv
// Conditions the raw user pins into clean levels, edge pulses and toggles.
// Downstream: level_out[CH_RESET] is the counter reset, toggle_out[CH_BUTTON]|level_out[CH_ENABLE] its enable.
module io_input_conditioner
    import user_io_pkg::*;
#(
    parameter int NUM_INPUTS      = 4,
    parameter int SYNC_STAGES     = 2,
`ifdef SIM
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM
`else
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_HW
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_INPUTS-1:0] raw_in,
    output logic [NUM_INPUTS-1:0] level_out,
    output logic [NUM_INPUTS-1:0] rise_pulse,
    output logic [NUM_INPUTS-1:0] fall_pulse,
    output logic [NUM_INPUTS-1:0] toggle_out
);

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw_in[i]),
            .level (level_out[i]),
            .rise  (rise_pulse[i]),
            .fall  (fall_pulse[i]),
            .toggle(toggle_out[i])
        );
    end

endmodule
